// File: rtl/screen_pkg.sv
// Shared definitions for the screen sequencer: FSM states, 7-segment
// character codes, the MAIN banner text and the active-low digit enables.
package screen_pkg;

  typedef enum logic [1:0] {
    MAIN   = 2'd0,
    PLAY   = 2'd1,
    RESULT = 2'd2
  } state_e;

  // Character codes above the 0..15 hex range
  localparam logic [4:0] CH_P     = 5'd16;
  localparam logic [4:0] CH_R     = 5'd17;
  localparam logic [4:0] CH_S     = 5'd18;
  localparam logic [4:0] CH_US    = 5'd19;
  localparam logic [4:0] CH_BLANK = 5'd20;
  localparam logic [4:0] CH_DASH  = 5'd21;

  // "PrESS_01", leftmost digit in [39:35]
  localparam logic [39:0] MAIN_BANNER =
    {CH_P, CH_R, 5'd14, CH_S, CH_S, CH_US, 5'd0, 5'd1};

  // Digit enables, active-low, bit 7 = leftmost (digit index 0)
  localparam logic [7:0] COM_OFF = 8'hFF;
  localparam logic [7:0] COM_D0  = 8'b0111_1111;
  localparam logic [7:0] COM_D1  = 8'b1011_1111;
  localparam logic [7:0] COM_D2  = 8'b1101_1111;
  localparam logic [7:0] COM_D3  = 8'b1110_1111;
  localparam logic [7:0] COM_D4  = 8'b1111_0111;
  localparam logic [7:0] COM_D5  = 8'b1111_1011;
  localparam logic [7:0] COM_D6  = 8'b1111_1101;
  localparam logic [7:0] COM_D7  = 8'b1111_1110;

  function automatic logic [7:0] com_for_digit(input logic [2:0] idx);
    logic [7:0] com;
    case (idx)
      3'd0:    com = COM_D0;
      3'd1:    com = COM_D1;
      3'd2:    com = COM_D2;
      3'd3:    com = COM_D3;
      3'd4:    com = COM_D4;
      3'd5:    com = COM_D5;
      3'd6:    com = COM_D6;
      default: com = COM_D7;
    endcase
    return com;
  endfunction

endpackage

// File: rtl/seg_font.sv
// Combinational 5-bit character code to 7-segment pattern.
// Ports:
//   code - character code (0..15 hex, 16 P, 17 r, 18 S, 19 _, 21 -, others blank)
//   seg  - segments {g,f,e,d,c,b,a}, 1 = lit
module seg_font
  import screen_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = '0;
    case (code)
      5'd0:    seg = 7'b0111111;
      5'd1:    seg = 7'b0000110;
      5'd2:    seg = 7'b1011011;
      5'd3:    seg = 7'b1001111;
      5'd4:    seg = 7'b1100110;
      5'd5:    seg = 7'b1101101;
      5'd6:    seg = 7'b1111101;
      5'd7:    seg = 7'b0000111;
      5'd8:    seg = 7'b1111111;
      5'd9:    seg = 7'b1101111;
      5'd10:   seg = 7'b1110111;
      5'd11:   seg = 7'b1111100;
      5'd12:   seg = 7'b0111001;
      5'd13:   seg = 7'b1011110;
      5'd14:   seg = 7'b1111001;
      5'd15:   seg = 7'b1110001;
      CH_P:    seg = 7'b1110011;
      CH_R:    seg = 7'b1010000;
      CH_S:    seg = 7'b1101101;
      CH_US:   seg = 7'b0001000;
      CH_DASH: seg = 7'b1000000;
      default: seg = '0;
    endcase
  end

endmodule

// File: rtl/screen_sequencer.sv
// Screen controller for the keypad/7-segment game board. Sequences the
// MAIN, PLAY and RESULT screens and multiplexes the 8-digit display.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   key_data        - keypad level lines, 1 = held
//   game_done       - one-cycle strobe, round ended
//   game_digits     - PLAY text, 8 x 5-bit codes, [39:35] leftmost
//   result_digits   - RESULT text, same packing
//   game_start      - one-cycle pulse on MAIN -> PLAY
//   is_main/is_play/is_result - registered one-hot state flags
//   seg_txt         - segments {g,f,e,d,c,b,a}, 1 = lit
//   seg_com         - digit enables, active-low, bit 7 leftmost
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 25000,
  parameter int unsigned RESULT_HOLD = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_data,
  input  logic        game_done,
  input  logic [39:0] game_digits,
  input  logic [39:0] result_digits,
  output logic        game_start,
  output logic        is_main,
  output logic        is_play,
  output logic        is_result,
  output logic [6:0]  seg_txt,
  output logic [7:0]  seg_com
);

  state_e      state_q, state_d;
  logic [2:0]  flags_q, flags_d;
  logic        start_q, start_d;
  logic        key_lvl_q, key_lvl_d;
  logic        key_any_q, key_any_d;
  logic        key_mask_q, key_mask_d;
  logic [31:0] div_q, div_d;
  logic [2:0]  dig_q, dig_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  seg_com_q, seg_com_d;
  logic [6:0]  seg_txt_q, seg_txt_d;

  logic        key_event;
  logic        scan_tick;
  logic        hold_to;
  logic [39:0] text_sel;
  logic [4:0]  code_sel;
  logic [6:0]  font_seg;

  seg_font u_font (
    .code (code_sel),
    .seg  (font_seg)
  );

  always_comb begin
    key_lvl_d = |key_data;
    key_any_d = key_lvl_q;
    // The mask is set by reset and drops only once every key is released,
    // so a key held across reset never yields an event.
    key_mask_d = key_mask_q & key_lvl_d;
    key_event  = key_lvl_q & ~key_any_q & ~key_mask_q;

    scan_tick = (div_q == SCAN_DIV - 1);
    div_d     = scan_tick ? '0 : div_q + 32'd1;
    dig_d     = scan_tick ? dig_q + 3'd1 : dig_q;
    hold_to   = scan_tick && (hold_q == RESULT_HOLD - 1);

    state_d = state_q;
    start_d = 1'b0;
    hold_d  = hold_q;
    case (state_q)
      MAIN: begin
        if (key_event) begin
          state_d = PLAY;
          start_d = 1'b1;
        end
      end
      PLAY: begin
        if (game_done) begin
          state_d = RESULT;
          hold_d  = '0;
        end
      end
      RESULT: begin
        if (key_event || hold_to) state_d = MAIN;
        else if (scan_tick)       hold_d  = hold_q + 32'd1;
      end
      default: state_d = MAIN;
    endcase

    flags_d = {state_d == RESULT, state_d == PLAY, state_d == MAIN};

    case (state_q)
      PLAY:    text_sel = game_digits;
      RESULT:  text_sel = result_digits;
      default: text_sel = MAIN_BANNER;
    endcase
    code_sel = text_sel[5 * (3'd7 - dig_q) +: 5];

    // Enables and segments load together on the tick to avoid ghosting
    seg_com_d = seg_com_q;
    seg_txt_d = seg_txt_q;
    if (scan_tick) begin
      seg_com_d = com_for_digit(dig_q);
      seg_txt_d = font_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MAIN;
      flags_q    <= 3'b001;
      start_q    <= 1'b0;
      key_lvl_q  <= 1'b0;
      key_any_q  <= 1'b0;
      key_mask_q <= 1'b1;
      div_q      <= '0;
      dig_q      <= '0;
      hold_q     <= '0;
      seg_com_q  <= COM_OFF;
      seg_txt_q  <= '0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      start_q    <= start_d;
      key_lvl_q  <= key_lvl_d;
      key_any_q  <= key_any_d;
      key_mask_q <= key_mask_d;
      div_q      <= div_d;
      dig_q      <= dig_d;
      hold_q     <= hold_d;
      seg_com_q  <= seg_com_d;
      seg_txt_q  <= seg_txt_d;
    end
  end

  assign is_main    = flags_q[0];
  assign is_play    = flags_q[1];
  assign is_result  = flags_q[2];
  assign game_start = start_q;
  assign seg_com    = seg_com_q;
  assign seg_txt    = seg_txt_q;

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;

  localparam int SD = 4;
  localparam int RH = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] key_data;
  logic        game_done;
  logic [39:0] game_digits;
  logic [39:0] result_digits;
  logic        game_start, is_main, is_play, is_result;
  logic [6:0]  seg_txt;
  logic [7:0]  seg_com;

  screen_sequencer #(.SCAN_DIV(SD), .RESULT_HOLD(RH)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_data      (key_data),
    .game_done     (game_done),
    .game_digits   (game_digits),
    .result_digits (result_digits),
    .game_start    (game_start),
    .is_main       (is_main),
    .is_play       (is_play),
    .is_result     (is_result),
    .seg_txt       (seg_txt),
    .seg_com       (seg_com)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  typedef struct { logic [4:0] code; logic [6:0] seg; } font_vec_t;
  typedef struct { logic [7:0] com;  logic [6:0] txt; } disp_vec_t;
  font_vec_t   font_tbl [24];
  disp_vec_t   banner_tbl [8];
  logic [6:0]  font_ref [32];
  logic [39:0] banner_ref;

  // ---------------- reference model ----------------
  int   m_state;          // 0 MAIN, 1 PLAY, 2 RESULT
  bit   m_start;
  logic [7:0] m_com;
  logic [6:0] m_txt;
  bit   h1, h2, need_rel, m_valid = 0;
  int   c, entry_c;

  task automatic model_step();
    bit ev, tk, to;
    int idx, nxt;
    logic [39:0] src;
    if (rst) begin
      m_state = 0; m_start = 0; m_com = 8'hFF; m_txt = '0;
      h1 = 0; h2 = 0; need_rel = 1; c = 0; entry_c = 0; m_valid = 1;
    end else if (m_valid) begin
      ev  = h1 && !h2 && !need_rel;
      tk  = (c % SD) == SD - 1;
      to  = (m_state == 2) && tk && (((c + 1) / SD - entry_c / SD) == RH);
      src = (m_state == 0) ? banner_ref : (m_state == 1) ? game_digits : result_digits;
      if (tk) begin
        idx   = (c / SD) % 8;
        m_com = ~(8'h80 >> idx);
        m_txt = font_ref[src[(7 - idx) * 5 +: 5]];
      end
      nxt = m_state;
      m_start = 0;
      case (m_state)
        0: if (ev) begin nxt = 1; m_start = 1; end
        1: if (game_done) begin nxt = 2; entry_c = c + 1; end
        default: if (ev || to) nxt = 0;
      endcase
      m_state  = nxt;
      need_rel = need_rel && (key_data != 0);
      h2 = h1;
      h1 = (key_data != 0);
      c++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid)
      chk("cycle_model",
          64'({is_main, is_play, is_result, game_start, seg_com, seg_txt}),
          64'({m_state == 0, m_state == 1, m_state == 2, m_start, m_com, m_txt}));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic wait_changes(input int target, output int got);
    logic [7:0] prev;
    prev = seg_com;
    got = 0;
    for (int i = 0; i < 200 && got < target; i++) begin
      cyc(1);
      if (seg_com !== prev) got++;
      prev = seg_com;
    end
  endtask

  task automatic wait_exit(output int got);
    logic [7:0] prev;
    prev = seg_com;
    got = 0;
    for (int i = 0; i < 200 && !is_main; i++) begin
      cyc(1);
      if (seg_com !== prev) got++;
      prev = seg_com;
    end
  endtask

  task automatic enter_result();
    key_data = 12'h002; cyc(3);
    key_data = '0;      cyc(3);
    game_done = 1'b1;   cyc(1);
    game_done = 1'b0;
    chk("enter_result", 64'(is_result), 64'(1));
  endtask

  initial begin
    int pulses, at, n, got;
    logic [63:0] r64;

    font_tbl[0]  = '{5'd0,  7'b0111111}; font_tbl[1]  = '{5'd1,  7'b0000110};
    font_tbl[2]  = '{5'd2,  7'b1011011}; font_tbl[3]  = '{5'd3,  7'b1001111};
    font_tbl[4]  = '{5'd4,  7'b1100110}; font_tbl[5]  = '{5'd5,  7'b1101101};
    font_tbl[6]  = '{5'd6,  7'b1111101}; font_tbl[7]  = '{5'd7,  7'b0000111};
    font_tbl[8]  = '{5'd8,  7'b1111111}; font_tbl[9]  = '{5'd9,  7'b1101111};
    font_tbl[10] = '{5'd10, 7'b1110111}; font_tbl[11] = '{5'd11, 7'b1111100};
    font_tbl[12] = '{5'd12, 7'b0111001}; font_tbl[13] = '{5'd13, 7'b1011110};
    font_tbl[14] = '{5'd14, 7'b1111001}; font_tbl[15] = '{5'd15, 7'b1110001};
    font_tbl[16] = '{5'd16, 7'b1110011}; font_tbl[17] = '{5'd17, 7'b1010000};
    font_tbl[18] = '{5'd18, 7'b1101101}; font_tbl[19] = '{5'd19, 7'b0001000};
    font_tbl[20] = '{5'd20, 7'b0000000}; font_tbl[21] = '{5'd21, 7'b1000000};
    font_tbl[22] = '{5'd25, 7'b0000000}; font_tbl[23] = '{5'd31, 7'b0000000};
    for (int i = 0; i < 32; i++) font_ref[i] = '0;
    for (int i = 0; i < 24; i++) font_ref[font_tbl[i].code] = font_tbl[i].seg;

    banner_tbl[0] = '{8'h7F, 7'b1110011}; banner_tbl[1] = '{8'hBF, 7'b1010000};
    banner_tbl[2] = '{8'hDF, 7'b1111001}; banner_tbl[3] = '{8'hEF, 7'b1101101};
    banner_tbl[4] = '{8'hF7, 7'b1101101}; banner_tbl[5] = '{8'hFB, 7'b0001000};
    banner_tbl[6] = '{8'hFD, 7'b0111111}; banner_tbl[7] = '{8'hFE, 7'b0000110};
    banner_ref = {5'd16, 5'd17, 5'd14, 5'd18, 5'd18, 5'd19, 5'd0, 5'd1};

    // Reset values
    rst = 1'b1; key_data = '0; game_done = 1'b0; game_digits = '0;
    result_digits = {5'd10, 5'd11, 5'd12, 5'd13, 5'd21, 5'd3, 5'd2, 5'd1};
    cyc(3);
    chk("rst_is_main", 64'({is_main, is_play, is_result}), 64'(3'b100));
    chk("rst_start", 64'(game_start), 64'(0));
    chk("rst_seg_com", 64'(seg_com), 64'(8'hFF));
    chk("rst_seg_txt", 64'(seg_txt), 64'(0));
    rst = 1'b0;

    // Banner scan in MAIN
    for (int i = 0; i < 20 && seg_com === 8'hFF; i++) cyc(1);
    for (int i = 0; i < 8; i++) begin
      chk("banner_com", 64'(seg_com), 64'(banner_tbl[i].com));
      chk("banner_txt", 64'(seg_txt), 64'(banner_tbl[i].txt));
      cyc(SD);
    end
    chk("idle_main", 64'(is_main), 64'(1));

    // Held key: one start pulse two cycles after the rise
    key_data = 12'h004;
    pulses = 0; at = -1;
    for (int i = 1; i <= 50; i++) begin
      cyc(1);
      if (game_start) begin pulses++; if (at < 0) at = i; end
      if (i == 2 || i == 50) chk("play_while_held", 64'(is_play), 64'(1));
    end
    chk("start_pulses", 64'(pulses), 64'(1));
    chk("start_latency", 64'(at), 64'(2));
    key_data = '0; cyc(3);

    // PLAY text: all 8s, then font table
    game_digits = {8{5'd8}};
    cyc(8);
    for (int i = 0; i < 8; i++) begin
      chk("play_digit8", 64'(seg_txt), 64'(7'b1111111));
      cyc(SD);
    end
    for (int i = 0; i < 24; i++) begin
      game_digits = {8{font_tbl[i].code}};
      cyc(8);
      chk("font", 64'(seg_txt), 64'(font_tbl[i].seg));
    end

    // Keys ignored in PLAY; done moves to RESULT next cycle
    key_data = 12'h800; cyc(3); key_data = '0; cyc(5);
    chk("play_ignores_key", 64'(is_play), 64'(1));
    game_done = 1'b1; cyc(1); game_done = 1'b0;
    chk("done_to_result", 64'(is_result), 64'(1));

    // RESULT timeout on the 10th tick
    wait_exit(got);
    chk("timeout_ticks", 64'(got), 64'(RH));

    // game_done in MAIN ignored
    game_done = 1'b1; cyc(1); game_done = 1'b0; cyc(2);
    chk("done_in_main_ignored", 64'(is_main), 64'(1));

    // RESULT: done ignored, key after tick 5 exits immediately
    enter_result();
    game_done = 1'b1; cyc(1); game_done = 1'b0; cyc(1);
    chk("done_in_result_ignored", 64'(is_result), 64'(1));
    wait_changes(6, got);
    chk("result_ticks_before_key", 64'(got), 64'(6));
    key_data = 12'h001; n = 0;
    while (!is_main && n < 10) begin cyc(1); n++; end
    chk("key_exit_latency", 64'(n), 64'(2));
    key_data = '0; cyc(3);

    // Hold count restarts on re-entry
    enter_result();
    wait_exit(got);
    chk("hold_restart_ticks", 64'(got), 64'(RH));

    // Key event coincides with the 10th tick
    enter_result();
    wait_changes(9, got);
    chk("coincide_ticks", 64'(got), 64'(9));
    cyc(2);
    key_data = 12'h010; n = 0;
    while (!is_main && n < 10) begin cyc(1); n++; end
    chk("coincide_exit", 64'(n), 64'(2));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (game_start) pulses++; end
    chk("coincide_no_start", 64'(pulses), 64'(0));
    chk("coincide_stay_main", 64'(is_main), 64'(1));
    key_data = '0; cyc(3);

    // Reset in RESULT with a key held
    enter_result();
    rst = 1'b1; key_data = 12'h020; cyc(1); rst = 1'b0;
    chk("rst_mid_main", 64'(is_main), 64'(1));
    chk("rst_mid_com", 64'(seg_com), 64'(8'hFF));
    pulses = 0;
    for (int i = 0; i < 20; i++) begin cyc(1); if (game_start) pulses++; end
    chk("held_through_rst", 64'(pulses), 64'(0));
    key_data = '0; cyc(3);
    key_data = 12'h020; n = 0;
    while (!game_start && n < 10) begin cyc(1); n++; end
    chk("start_after_repress", 64'(game_start), 64'(1));
    key_data = '0; cyc(3);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        key_data = ($urandom_range(0, 9) < 6) ? 12'h000 : 12'($urandom());
      game_done = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) begin
        r64 = {$urandom(), $urandom()};
        game_digits = r64[39:0];
      end
      if ($urandom_range(0, 31) == 0) begin
        r64 = {$urandom(), $urandom()};
        result_digits = r64[39:0];
      end
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0; key_data = '0; game_done = 1'b0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
